// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// instruction field positions.
package ula_pkg;

  localparam logic [2:0] LOAD   = 3'b000;
  localparam logic [2:0] ADD    = 3'b001;
  localparam logic [2:0] ADDI   = 3'b010;
  localparam logic [2:0] SUB    = 3'b011;
  localparam logic [2:0] SUBI   = 3'b100;
  localparam logic [2:0] MUL    = 3'b101;
  localparam logic [2:0] CLR    = 3'b110;
  localparam logic [2:0] ILEGAL = 3'b111;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 9;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  typedef enum logic [1:0] {OCIOSO, DECOD, EXEC, ESCREVE} estado_t;

  // Ops whose second operand comes from the immediate field
  function automatic logic usa_imm(input logic [2:0] op);
    return (op == LOAD) || (op == ADDI) || (op == SUBI);
  endfunction

  function automatic logic eh_alu(input logic [2:0] op);
    return (op == ADD) || (op == ADDI) || (op == SUB) || (op == SUBI) || (op == MUL);
  endfunction

endpackage

// File: rtl/banco_regs.sv
// 4x8 register bank: one write port, bulk clear, three combinational reads.
module banco_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic       clr,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] rs1_sel,
  input  logic [1:0] rs2_sel,
  input  logic [1:0] dbg_sel,
  output logic [7:0] rs1_data,
  output logic [7:0] rs2_data,
  output logic [7:0] dbg_data
);

  logic [7:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = regs[rs1_sel];
  assign rs2_data = regs[rs2_sel];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/controle_ula.sv
// Multi-cycle sequencer driving an external combinational 8-bit ALU:
// fetch by handshake, decode operands, dwell in EXEC, write back.
module controle_ula
  import ula_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_res,
  output logic [7:0]  resultado,
  output logic        done,
  output logic        erro,
  output logic        zero,
  output logic        neg,
  input  logic [1:0]  reg_sel,
  output logic [7:0]  reg_out
);

  estado_t     estado, prox;
  logic [15:0] instr_q;
  logic [7:0]  cnt;
  logic [7:0]  rs1_data, rs2_data;
  logic [2:0]  op_q;
  logic [7:0]  imm_q;
  logic        escreve_ok;

  assign op_q  = instr_q[OP_HI:OP_LO];
  assign imm_q = instr_q[IMM_HI:IMM_LO];

  assign instr_ready = (estado == OCIOSO) && !rst;
  assign escreve_ok  = (estado == ESCREVE) && !rst;
  assign done        = escreve_ok && (op_q != ILEGAL);
  assign erro        = escreve_ok && (op_q == ILEGAL);

  banco_regs u_banco (
    .clk      (clk),
    .rst      (rst),
    .we       (done && (op_q != CLR)),
    .clr      (done && (op_q == CLR)),
    .waddr    (instr_q[RD_HI:RD_LO]),
    .wdata    (resultado),
    .rs1_sel  (instr_q[RS1_HI:RS1_LO]),
    .rs2_sel  (instr_q[RS2_HI:RS2_LO]),
    .dbg_sel  (reg_sel),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (reg_out)
  );

  always_ff @(posedge clk) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (instr_valid) prox = DECOD;
      DECOD:   prox = eh_alu(op_q) ? EXEC : ESCREVE;
      EXEC:    if (cnt == 8'd0) prox = ESCREVE;
      ESCREVE: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // Result and flags are settled on entry to ESCREVE so they are visible alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= 16'h0000;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 3'b000;
      cnt       <= 8'd0;
      resultado <= 8'h00;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: if (instr_valid) instr_q <= instr;
        DECOD: begin
          alu_a  <= rs1_data;
          alu_b  <= usa_imm(op_q) ? imm_q : rs2_data;
          alu_op <= op_q;
          cnt    <= (op_q == MUL) ? 8'(MUL_CYCLES - 1) : 8'd0;
          if (op_q == LOAD) begin
            resultado <= imm_q;
            zero      <= (imm_q == 8'h00);
            neg       <= imm_q[7];
          end else if (op_q == CLR) begin
            resultado <= 8'h00;
            zero      <= 1'b1;
            neg       <= 1'b0;
          end
        end
        EXEC: begin
          if (cnt == 8'd0) begin
            resultado <= alu_res;
            zero      <= (alu_res == 8'h00);
            neg       <= alu_res[7];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_ula.sv
// Directed self-checking bench for controle_ula with a behavioural ALU beside it.
module tb_controle_ula;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  alu_a, alu_b, alu_res, resultado, reg_out;
  logic [2:0]  alu_op;
  logic        done, erro, zero, neg;
  logic [1:0]  reg_sel = 2'd0;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  logic [7:0] aSeen [8];
  logic [7:0] bSeen [8];

  controle_ula #(.MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .resultado(resultado), .done(done), .erro(erro),
    .zero(zero), .neg(neg), .reg_sel(reg_sel), .reg_out(reg_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external combinational ALU
  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      ADD, ADDI: alu_res = alu_a + alu_b;
      SUB, SUBI: alu_res = alu_a - alu_b;
      MUL:       alu_res = 8'((16'(alu_a) * 16'(alu_b)) & 16'h00FF);
      default:   alu_res = 8'h00;
    endcase
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [7:0] lo);
    return {op, rd, rs1, 1'b0, lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ins, output int tHs);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    tHs = -1;
    for (int c = 0; c < 20; c++) begin
      if (instr_ready) begin
        tHs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (tHs < 0) checkOutput("hs_timeout", 0, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic waitEnd(input int tHs, output int lat, output logic gDone, output logic gErro,
                         output logic [7:0] res, output logic z, output logic n);
    lat = -1; gDone = 1'b0; gErro = 1'b0; res = 8'h00; z = 1'b0; n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cyc - tHs < 8) begin
        aSeen[cyc - tHs] = alu_a;
        bSeen[cyc - tHs] = alu_b;
      end
      if (done || erro) begin
        lat = cyc - tHs; gDone = done; gErro = erro;
        res = resultado; z = zero; n = neg;
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic readReg(input logic [1:0] s, output logic [7:0] v);
    @(negedge clk);
    reg_sel = s;
    #1 v = reg_out;
  endtask

  task automatic runOp(input string tag, input logic [15:0] ins, input int expLat,
                       input logic [7:0] expRes, input logic expZ, input logic expN);
    int t, lat;
    logic gd, ge, z, n;
    logic [7:0] r;
    applyStimulus(ins, t);
    waitEnd(t, lat, gd, ge, r, z, n);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_done"}, {gd, ge}, 2'b10);
    checkOutput({tag, "_res"}, r, expRes);
    checkOutput({tag, "_zn"}, {z, n}, {expZ, expN});
  endtask

  initial begin
    int t, lat, k, lowCnt, nDone;
    int hs [3];
    logic gd, ge, z, n, swap;
    logic [7:0] r, v;
    logic [15:0] queue3 [3];

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ready", instr_ready, 0);
    checkOutput("rst_outs", {done, erro, zero, neg, resultado, alu_a, alu_b, alu_op}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rst_release_ready", instr_ready, 1);

    runOp("load_r1", mk(LOAD, 1, 0, 8'd7), 2, 8'd7, 0, 0);
    runOp("load_r2", mk(LOAD, 2, 0, 8'd5), 2, 8'd5, 0, 0);
    runOp("add_r3", mk(ADD, 3, 1, 8'd2), 3, 8'd12, 0, 0);
    readReg(3, v); checkOutput("reg3_add", v, 8'd12);

    runOp("subi_r0", mk(SUBI, 0, 1, 8'd9), 3, 8'hFE, 0, 1);
    runOp("sub_r2", mk(SUB, 2, 2, 8'd2), 3, 8'h00, 1, 0);
    readReg(2, v); checkOutput("reg2_sub", v, 8'h00);

    runOp("load_r1_20", mk(LOAD, 1, 0, 8'd20), 2, 8'd20, 0, 0);
    runOp("load_r2_13", mk(LOAD, 2, 0, 8'd13), 2, 8'd13, 0, 0);
    applyStimulus(mk(MUL, 3, 1, 8'd2), t);
    waitEnd(t, lat, gd, ge, r, z, n);
    checkOutput("mul_lat", lat, 4);
    checkOutput("mul_res", r, 8'd4);
    checkOutput("mul_a_held", {aSeen[2], aSeen[3]}, {8'd20, 8'd20});
    checkOutput("mul_b_held", {bSeen[2], bSeen[3]}, {8'd13, 8'd13});
    checkOutput("mul_op", alu_op, MUL);

    runOp("load_r0_55", mk(LOAD, 0, 0, 8'h55), 2, 8'h55, 0, 0);
    runOp("load_r1_80", mk(LOAD, 1, 0, 8'h80), 2, 8'h80, 0, 1);
    applyStimulus(mk(ILEGAL, 0, 1, 8'd2), t);
    waitEnd(t, lat, gd, ge, r, z, n);
    checkOutput("ileg_lat", lat, 2);
    checkOutput("ileg_flags", {gd, ge}, 2'b01);
    checkOutput("ileg_zn", {z, n}, 2'b01);
    readReg(0, v); checkOutput("ileg_r0", v, 8'h55);

    // Abort a MUL mid-EXEC, with a pending instruction present during reset
    applyStimulus(mk(MUL, 3, 1, 8'd2), t);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    instr = mk(LOAD, 3, 0, 8'h11);
    instr_valid = 1'b1;
    #1 checkOutput("abort_ready_rst", instr_ready, 0);
    @(negedge clk);
    checkOutput("abort_done_rst", {done, erro}, 0);
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    #1 checkOutput("abort_ready_after", instr_ready, 1);
    nDone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || erro) nDone++;
    end
    checkOutput("abort_no_done", nDone, 0);
    for (int i = 0; i < 4; i++) begin
      readReg(2'(i), v);
      checkOutput($sformatf("abort_reg%0d", i), v, 0);
    end

    runOp("load_r1_1", mk(LOAD, 1, 0, 8'd1), 2, 8'd1, 0, 0);
    runOp("load_r2_2", mk(LOAD, 2, 0, 8'd2), 2, 8'd2, 0, 0);
    queue3[0] = mk(ADD, 3, 1, 8'd2);
    queue3[1] = mk(ADD, 0, 3, 8'd1);
    queue3[2] = mk(ADD, 1, 0, 8'd3);
    k = 0; lowCnt = 0; nDone = 0;
    @(negedge clk);
    instr = queue3[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      swap = 1'b0;
      if (c > 0) @(negedge clk);
      if (done) nDone++;
      if (k >= 1 && k < 3 && !instr_ready) lowCnt++;
      if (instr_ready && instr_valid && k < 3) begin
        hs[k] = cyc;
        k++;
        swap = 1'b1;
      end
      @(posedge clk);
      #1;
      if (swap) begin
        if (k < 3) instr = queue3[k];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    checkOutput("b2b_count", k, 3);
    checkOutput("b2b_gap1", hs[1] - hs[0], 4);
    checkOutput("b2b_gap2", hs[2] - hs[1], 4);
    checkOutput("b2b_ready_low", lowCnt, 6);
    checkOutput("b2b_dones", nDone, 3);
    readReg(3, v); checkOutput("b2b_r3", v, 8'd3);
    readReg(0, v); checkOutput("b2b_r0", v, 8'd4);
    readReg(1, v); checkOutput("b2b_r1", v, 8'd7);

    runOp("clr", mk(CLR, 0, 0, 8'h00), 2, 8'h00, 1, 0);
    readReg(1, v); checkOutput("clr_r1", v, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/controle_ula.md
# controle_ula

Multi-cycle sequencer that sits between the instruction source and the combinational 8-bit ALU. It accepts one 16-bit instruction per valid/ready handshake, reads operands from a private 4×8 register bank, and drives the ALU operand/opcode lines. It then writes the result back and reports completion with `done` and the `zero`/`neg` flags. Illegal opcodes are rejected with `erro`.

## Interface
- `MUL_CYCLES`, default 2: execute-state dwell for MUL (≥1); all other ALU ops dwell 1 cycle.
- `clk  in  1`: single clock; everything is sampled on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `instr  in  16`: [15:13] opcode, [12:11] rd, [10:9] rs1, [8] unused, [7:0] imm (I-type) / [1:0] rs2 (R-type).
- `instr_valid  in  1`: `instr` is valid.
- `instr_ready  out  1`: high only in OCIOSO with `rst`=0.
- `alu_a  out  8`, `alu_b  out  8`: registered ALU operands.
- `alu_op  out  3`: registered ALU opcode.
- `alu_res  in  8`: combinational ALU result.
- `resultado  out  8`: value written, valid while `done`=1.
- `done  out  1`: one-cycle completion pulse.
- `erro  out  1`: one-cycle pulse on an illegal opcode.
- `zero  out  1`, `neg  out  1`: flags of the last written value; `neg` = bit 7.
- `reg_sel  in  2`, `reg_out  out  8`: combinational debug read of the register bank.

## Operation
- Opcodes:
  - 000 LOAD: rd ← imm.
  - 001 ADD: rd ← rs1+rs2.
  - 010 ADDI: rd ← rs1+imm.
  - 011 SUB: rd ← rs1−rs2.
  - 100 SUBI: rd ← rs1−imm.
  - 101 MUL: rd ← rs1×rs2.
  - 110 CLR: all registers ← 0.
  - 111: illegal.
- Arithmetic is modulo 256: the low 8 bits of `alu_res` are written. No carry or overflow flag.
- FSM states:
  - OCIOSO: `instr_ready`=1. On handshake, latch `instr` and go to DECOD.
  - DECOD: read rs1/rs2 and load `alu_a` = rs1 and `alu_b` = rs2 or imm. Load `alu_op` = opcode.
    - ALU ops go to EXEC and load the dwell counter.
    - LOAD, CLR and 111 go to ESCREVE.
  - EXEC: hold `alu_a`, `alu_b` and `alu_op` stable. Decrement the counter. At count 0, capture `alu_res` and go to ESCREVE.
  - ESCREVE: perform the register write (none for 111). Assert `done` (or `erro` instead, for 111). Update `zero`/`neg` except on 111. Go to OCIOSO.
- CLR: `resultado` = 0, `zero`=1, `neg`=0.
- `instr_valid` while not ready is ignored. The source holds the instruction until the handshake.
- `reg_out` reflects writes from the cycle after ESCREVE.

## Timing
- Handshake in cycle T. DECOD at T+1.
- ALU ops: EXEC T+2 … T+1+N, where N = 1, or N = `MUL_CYCLES` for MUL. ESCREVE with `done` at T+2+N.
- ADD/SUB latency is therefore 3 cycles.
- LOAD/CLR/illegal: `done`/`erro` at T+2.
- Back-to-back: the next handshake is possible at the cycle after ESCREVE (T+3+N). Throughput is one instruction per 4+N−1 cycles for ALU ops.
- Reset values: state OCIOSO; registers, `alu_a`, `alu_b`, `alu_op`, `resultado`, `done`, `erro`, `zero` and `neg` all 0; `instr_ready`=0 while `rst`=1.
- Reset in any state, including mid-MUL: the operation is aborted, with no write and no `done`. `instr_ready`=1 on the first cycle with `rst`=0.
- `rst` and `instr_valid` in the same cycle: reset wins and no instruction is accepted.
- rd equal to rs1 or rs2 is legal: operands are captured in DECOD, before the write.

## Structure
- Shared package `ula_pkg`:
  - opcode localparams: LOAD, ADD, ADDI, SUB, SUBI, MUL, CLR, ILEGAL;
  - FSM state encoding: OCIOSO, DECOD, EXEC, ESCREVE;
  - instruction field bit positions.
- One sub-module, `banco_regs`: 4×8 registers with synchronous reset, one write port, and three combinational read ports (rs1, rs2, debug).
- The FSM, dwell counter and flags live in `controle_ula`. The ALU is instantiated alongside it, not inside it.

## Test plan
- LOAD r1=7; LOAD r2=5; ADD r3=r1+r2: `done` at T+3, `resultado`=12, `zero`=0, `neg`=0, `reg_out`(3)=12.
- SUBI r0=r1−9 with r1=7: `resultado`=0xFE, `neg`=1. Then SUB r2=r2−r2 with r2=5: `resultado`=0, `zero`=1.
- MUL with r1=20, r2=13, `MUL_CYCLES`=2: `alu_a`/`alu_b` held for 2 EXEC cycles; `done` at T+4; `resultado`=4 (260 mod 256).
- Opcode 111 with r0 preloaded to 0x55: `erro` pulse at T+2, no `done`; r0 still 0x55; `zero`/`neg` unchanged.
- `rst` pulsed during MUL EXEC: no `done`; all registers read 0; `instr_ready`=1 the cycle after `rst` falls.
- `instr_valid` held high with 3 queued ADDs: exactly 3 handshakes, one per 4 cycles. `instr_ready` is low from DECOD through ESCREVE.
